// File: rtl/aes_128_round_ctrl.sv
// Round sequencer for the iterative AES-128 core: IDLE -> LOAD -> RUN (3 phases x ROUNDS) -> DONE.
// Optional 32-bit completed-block counter enabled by macro AES_128_ROUND_CTRL_BLK_CNT_EN.
module aes_128_round_ctrl #(
   parameter int ROUNDS = 10
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_kill,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [3:0]  o_round,
   output logic [1:0]  o_phase,
   output logic        o_load_sel,
   output logic        o_state_we,
   output logic        o_sbox_rd,
   output logic        o_key_req,
   output logic        o_mixcol_en,
`ifdef AES_128_ROUND_CTRL_BLK_CNT_EN
   output logic [31:0] o_blk_cnt,
`endif
   output logic        o_mixcol_kill
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

   localparam logic [3:0] LP_LAST = 4'(ROUNDS);

   state_t     r_state;
   logic [3:0] r_round;
   logic [1:0] r_phase;
   logic       r_in_ready;
   logic       r_out_valid;
   logic       r_load_sel;
   logic       r_state_we;
   logic       r_sbox_rd;
   logic       r_key_req;
   logic       r_mixcol_en;
   logic       r_mixcol_kill;

   // Every output is decoded for the state being entered, so all outputs come straight from flops.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_round       <= 4'd0;
         r_phase       <= 2'd0;
         r_in_ready    <= 1'b1;
         r_out_valid   <= 1'b0;
         r_load_sel    <= 1'b0;
         r_state_we    <= 1'b0;
         r_sbox_rd     <= 1'b0;
         r_key_req     <= 1'b0;
         r_mixcol_en   <= 1'b0;
         r_mixcol_kill <= 1'b1;
      end else begin
         r_in_ready    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_load_sel    <= 1'b0;
         r_state_we    <= 1'b0;
         r_sbox_rd     <= 1'b0;
         r_key_req     <= 1'b0;
         r_mixcol_en   <= 1'b0;
         r_mixcol_kill <= 1'b0;
         if (i_kill) begin
            r_state       <= ST_IDLE;
            r_round       <= 4'd0;
            r_phase       <= 2'd0;
            r_in_ready    <= 1'b1;
            r_mixcol_kill <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (i_in_valid) begin
                     r_state    <= ST_LOAD;
                     r_round    <= 4'd0;
                     r_phase    <= 2'd0;
                     r_load_sel <= 1'b1;
                     r_state_we <= 1'b1;
                     r_key_req  <= 1'b1;
                  end else begin
                     r_in_ready    <= 1'b1;
                     r_mixcol_kill <= 1'b1;
                  end
               end
               ST_LOAD: begin
                  r_state   <= ST_RUN;
                  r_round   <= 4'd1;
                  r_phase   <= 2'd0;
                  r_sbox_rd <= 1'b1;
               end
               ST_RUN: begin
                  case (r_phase)
                     2'd0: begin
                        r_phase     <= 2'd1;
                        r_mixcol_en <= (r_round == LP_LAST);
                     end
                     2'd1: begin
                        r_phase    <= 2'd2;
                        r_state_we <= 1'b1;
                        // Request the next round key alongside the state write of this round.
                        r_key_req  <= (r_round != LP_LAST);
                     end
                     default: begin
                        if (r_round != LP_LAST) begin
                           r_round   <= r_round + 4'd1;
                           r_phase   <= 2'd0;
                           r_sbox_rd <= 1'b1;
                        end else begin
                           r_state     <= ST_DONE;
                           r_out_valid <= 1'b1;
                        end
                     end
                  endcase
               end
               ST_DONE: begin
                  if (i_out_ready) begin
                     r_state       <= ST_IDLE;
                     r_round       <= 4'd0;
                     r_phase       <= 2'd0;
                     r_in_ready    <= 1'b1;
                     r_mixcol_kill <= 1'b1;
                  end else begin
                     r_out_valid <= 1'b1;
                  end
               end
               default: begin
                  r_state       <= ST_IDLE;
                  r_round       <= 4'd0;
                  r_phase       <= 2'd0;
                  r_in_ready    <= 1'b1;
                  r_mixcol_kill <= 1'b1;
               end
            endcase
         end
      end
   end

   assign o_in_ready    = r_in_ready;
   assign o_out_valid   = r_out_valid;
   assign o_round       = r_round;
   assign o_phase       = r_phase;
   assign o_load_sel    = r_load_sel;
   assign o_state_we    = r_state_we;
   assign o_sbox_rd     = r_sbox_rd;
   assign o_key_req     = r_key_req;
   assign o_mixcol_en   = r_mixcol_en;
   assign o_mixcol_kill = r_mixcol_kill;

`ifdef AES_128_ROUND_CTRL_BLK_CNT_EN
   logic [31:0] r_blk_cnt;

   // Counts consumer handshakes only; abort does not touch it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_blk_cnt <= 32'd0;
      end else if (r_out_valid && i_out_ready) begin
         r_blk_cnt <= r_blk_cnt + 32'd1;
      end
   end

   assign o_blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_aes_128_round_ctrl.sv
// Directed bench for aes_128_round_ctrl with a behavioural AES datapath driven by the controller strobes.
module tb_aes_128_round_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        kill = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        o_in_ready, o_out_valid, o_load_sel, o_state_we, o_sbox_rd;
   logic        o_key_req, o_mixcol_en, o_mixcol_kill;
   logic [3:0]  o_round;
   logic [1:0]  o_phase;
`ifdef AES_128_ROUND_CTRL_BLK_CNT_EN
   logic [31:0] o_blk_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   aes_128_round_ctrl #(.ROUNDS(10)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_kill        (kill),
      .i_in_valid    (in_valid),
      .o_in_ready    (o_in_ready),
      .o_out_valid   (o_out_valid),
      .i_out_ready   (out_ready),
      .o_round       (o_round),
      .o_phase       (o_phase),
      .o_load_sel    (o_load_sel),
      .o_state_we    (o_state_we),
      .o_sbox_rd     (o_sbox_rd),
      .o_key_req     (o_key_req),
      .o_mixcol_en   (o_mixcol_en),
`ifdef AES_128_ROUND_CTRL_BLK_CNT_EN
      .o_blk_cnt     (o_blk_cnt),
`endif
      .o_mixcol_kill (o_mixcol_kill)
   );

   // {in_ready, out_valid, load_sel, state_we, sbox_rd, key_req, mixcol_en, mixcol_kill}
   wire [7:0] ctl = {o_in_ready, o_out_valid, o_load_sel, o_state_we,
                     o_sbox_rd, o_key_req, o_mixcol_en, o_mixcol_kill};
   localparam logic [7:0] CTL_IDLE = 8'b1000_0001;
   localparam logic [7:0] CTL_LOAD = 8'b0011_0100;

   localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0]  inv = 8'h01;
      logic [15:0] d;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      d = {inv, inv};
      return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o = '0;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         o[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0 = k[127:96], w1 = k[95:64], w2 = k[63:32], w3 = k[31:0];
      logic [31:0] t;
      t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Datapath: S-box stage, MixColumns register, state register and key expansion.
   logic [127:0] m_st = '0, m_sb = '0, m_mc = '0, m_rk = '0;
   logic [7:0]   m_rcon = 8'h01;
   always @(posedge clk) begin
      if (o_sbox_rd) m_sb <= sub_shift(m_st);
      if (o_mixcol_kill) m_mc <= '0;
      else               m_mc <= o_mixcol_en ? m_sb : mix_columns(m_sb);
      if (o_state_we) m_st <= o_load_sel ? (PT ^ KEY) : (m_mc ^ m_rk);
      if (o_key_req) begin
         if (o_load_sel) begin
            m_rk   <= expand(KEY, 8'h01);
            m_rcon <= 8'h02;
         end else begin
            m_rk   <= expand(m_rk, m_rcon);
            m_rcon <= xt(m_rcon);
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives in_valid into the accept edge; returns 1 ns after it, with LOAD visible.
   task automatic accept();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // Counts edges from the accept edge until out_valid is seen (bounded).
   task automatic run_to_done(inout int n);
      while (!o_out_valid && n < 60) begin
         step();
         n++;
      end
   endtask

   int n, kreq, mce, found;
   logic [5:0] mce_at;
   int acc[3];
   int na;
   logic rdy;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctl", 128'(ctl), 128'(CTL_IDLE));
      chk("reset_round_phase", 128'({o_round, o_phase}), 128'(6'd0));
      rst = 1'b0;
      step();

      // Single block with the FIPS-197 vector. The accept edge closes cycle T, so cycle T+32
      // (out_valid) opens at the 31st edge after the accept edge.
      out_ready = 1'b1;
      accept();
      chk("load_ctl", 128'(ctl), 128'(CTL_LOAD));
      kreq = int'(o_key_req);
      mce = 0;
      mce_at = '0;
      n = 0;
      while (!o_out_valid && n < 60) begin
         step();
         n++;
         kreq += int'(o_key_req);
         if (o_mixcol_en) begin
            mce++;
            mce_at = {o_round, o_phase};
         end
      end
      chk("single_latency_edges", 128'(n), 128'(31));
      chk("single_key_req_count", 128'(kreq), 128'(10));
      chk("single_mixcol_en_count", 128'(mce), 128'(1));
      chk("single_mixcol_en_at", 128'(mce_at), 128'({4'd10, 2'd1}));
      chk("fips197_ciphertext", m_st, CIPHER);
      step();
      chk("single_back_to_idle", 128'({ctl, o_round}), 128'({CTL_IDLE, 4'd0}));

      // Backpressure in DONE, with a stray in_valid that must be ignored
      out_ready = 1'b0;
      accept();
      n = 0;
      run_to_done(n);
      chk("bp_latency_edges", 128'(n), 128'(31));
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_valid_round", 128'({o_out_valid, o_in_ready, o_round}), 128'({1'b1, 1'b0, 4'd10}));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bp_idle_after_ready", 128'({ctl, o_round}), 128'({CTL_IDLE, 4'd0}));
      step();
      chk("bp_no_late_accept", 128'(ctl), 128'(CTL_IDLE));

      // Kill at round 5 phase 1
      accept();
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         if (o_round == 4'd5 && o_phase == 2'd1) found = 1;
         else step();
      end
      chk("kill_reached_r5p1", 128'(found), 128'(1));
      kill = 1'b1;
      step();
      kill = 1'b0;
      chk("kill_ctl_idle", 128'(ctl), 128'(CTL_IDLE));
      chk("kill_round_phase", 128'({o_round, o_phase}), 128'(6'd0));
      accept();
      n = 0;
      run_to_done(n);
      chk("kill_new_block_edges", 128'(n), 128'(31));
      chk("kill_new_block_cipher", m_st, CIPHER);
      step();
      chk("kill_new_block_idle", 128'(ctl), 128'(CTL_IDLE));

      // Asynchronous reset mid-run at round 3
      accept();
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         if (o_round == 4'd3) found = 1;
         else step();
      end
      chk("rst_reached_r3", 128'(found), 128'(1));
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_ctl", 128'(ctl), 128'(CTL_IDLE));
      chk("async_rst_round_phase", 128'({o_round, o_phase}), 128'(6'd0));
`ifdef AES_128_ROUND_CTRL_BLK_CNT_EN
      chk("async_rst_blk_cnt", 128'(o_blk_cnt), 128'(0));
`endif
      #1;
      rst = 1'b0;
      step();
      kill = 1'b1;
      in_valid = 1'b1;
      step();
      kill = 1'b0;
      in_valid = 1'b0;
      chk("kill_beats_in_valid", 128'({ctl, o_round}), 128'({CTL_IDLE, 4'd0}));
      step();
      chk("kill_beats_in_valid_2", 128'(ctl), 128'(CTL_IDLE));

      // Back-to-back blocks with out_ready held high
      out_ready = 1'b1;
      in_valid = 1'b1;
      na = 0;
      acc[0] = 0;
      acc[1] = 0;
      acc[2] = 0;
      rdy = o_in_ready;
      for (int e = 1; e <= 120 && na < 3; e++) begin
         @(posedge clk);
         if (rdy) begin
            acc[na] = e;
            na++;
         end
         #1;
         rdy = o_in_ready;
      end
      in_valid = 1'b0;
      chk("b2b_accepts", 128'(na), 128'(3));
      chk("b2b_gap_1", 128'(acc[1] - acc[0]), 128'(33));
      chk("b2b_gap_2", 128'(acc[2] - acc[1]), 128'(33));
      n = 0;
      run_to_done(n);
      chk("b2b_third_edges", 128'(n), 128'(31));
      chk("b2b_third_cipher", m_st, CIPHER);
      step();
      chk("b2b_final_idle", 128'(ctl), 128'(CTL_IDLE));
`ifdef AES_128_ROUND_CTRL_BLK_CNT_EN
      chk("b2b_blk_cnt", 128'(o_blk_cnt), 128'(3));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
